// File: rtl/ascii_output.sv
// CPU-facing character sink: paced TX writes land in a capture buffer that the
// host later drains through the ioctl upload port.
module ascii_output #(
    parameter int DEPTH_LOG2 = 12,
    parameter int PACE_DIV   = 4000
) (
    input  logic        clock_in,
    input  logic        rst,
    input  logic        cs,
    input  logic        we,
    input  logic        address,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    input  logic        ioctl_upload,
    input  logic        ioctl_rd,
    input  logic [15:0] ioctl_addr,
    output logic [7:0]  ioctl_din,
    output logic [15:0] text_length,
    output logic        text_avail
);
    // state  | meaning
    // IDLE   | ready for the next character (unless the buffer is full)
    // PACE   | character accepted, TX busy for PACE_DIV cycles
    // UPLOAD | host is draining the buffer, CPU data writes ignored

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int PW    = (PACE_DIV > 1) ? $clog2(PACE_DIV) : 1;
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [PW-1:0] PACE_LOAD = PW'(PACE_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PACE   = 2'd1,
        S_UPLOAD = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   r_pace;
    logic            r_overflow;
    logic [7:0]      r_last;
    logic            r_upload_q;
    logic [7:0]      r_mem [0:DEPTH-1];
    logic [7:0]      r_ram_q;
    logic            r_rd_hit;
    logic [7:0]      r_dout;

    logic            w_full;
    logic            w_tx_ready;
    logic            w_wr_data;
    logic            w_accept;
    logic            w_store;
    logic [7:0]      w_byte;
    logic            w_overflow_set;
    logic            w_clear_cpu;
    logic            w_upload_fall;
    logic            w_host_rd;
    logic            w_avail;

    always_ff @(posedge clock_in or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        if (ioctl_upload) begin
            w_state_nx = S_UPLOAD;
        end else begin
            case (r_state)
                S_IDLE:   if (w_accept) w_state_nx = S_PACE;
                S_PACE:   if (r_pace == '0) w_state_nx = S_IDLE;
                S_UPLOAD: w_state_nx = S_IDLE;
                default:  w_state_nx = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_full         = (r_count == FULL);
        w_tx_ready     = (r_state == S_IDLE) && !w_full;
        w_wr_data      = cs & we & ~address;
        // A rising upload wins over a same-cycle data write.
        w_accept       = w_wr_data & w_tx_ready & ~ioctl_upload;
        w_store        = w_accept & (din != 8'h0A);
        w_byte         = (din == 8'h0D) ? 8'h0A : {1'b0, din[6:0]};
        w_overflow_set = w_wr_data & w_full & (r_state == S_IDLE) & ~ioctl_upload;
        w_clear_cpu    = cs & we & address & din[0] & (r_state != S_UPLOAD);
        w_upload_fall  = r_upload_q & ~ioctl_upload;
        w_host_rd      = (r_state == S_UPLOAD) & ioctl_rd;
        w_avail        = (r_count != '0) & ~ioctl_upload;
    end

    always_ff @(posedge clock_in or posedge rst) begin
        if (rst) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_last     <= 8'h00;
            r_upload_q <= 1'b0;
        end else begin
            r_upload_q <= ioctl_upload;
            if (w_upload_fall || w_clear_cpu) begin
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_store) begin
                    r_count <= r_count + 1'b1;
                    r_last  <= w_byte;
                end
                if (w_overflow_set) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock_in or posedge rst) begin
        if (rst) begin
            r_pace <= '0;
        end else if (ioctl_upload) begin
            r_pace <= '0;
        end else if (w_accept) begin
            r_pace <= PACE_LOAD;
        end else if ((r_state == S_PACE) && (r_pace != '0)) begin
            r_pace <= r_pace - 1'b1;
        end
    end

    // Capture RAM: no reset, so it maps onto a plain block RAM.
    always_ff @(posedge clock_in) begin
        if (w_store) begin
            r_mem[r_count[DEPTH_LOG2-1:0]] <= w_byte;
        end
        if (w_host_rd) begin
            r_ram_q <= r_mem[ioctl_addr[DEPTH_LOG2-1:0]];
        end
    end

    always_ff @(posedge clock_in or posedge rst) begin
        if (rst) begin
            r_rd_hit <= 1'b0;
            r_dout   <= 8'h00;
        end else begin
            if (w_host_rd) begin
                r_rd_hit <= (32'(ioctl_addr) < 32'(r_count));
            end
            if (cs && !we) begin
                if (address) begin
                    r_dout <= {w_tx_ready, r_overflow, 5'b00000, w_avail};
                end else begin
                    r_dout <= (r_count != '0) ? r_last : 8'h00;
                end
            end
        end
    end

    assign dout        = r_dout;
    assign ioctl_din   = r_rd_hit ? r_ram_q : 8'h00;
    assign text_length = 16'(r_count);
    assign text_avail  = w_avail;

endmodule
